// File: rtl/amber48_pkg.sv
// Shared amber48 types and default constants for the fetch front end.
package amber48_pkg;

  localparam int XLEN              = 48;
  localparam int FETCH_INSTR_BYTES = 6;
  localparam int FETCH_DEPTH       = 4;
  localparam int FETCH_MAX_OUTST   = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } amber48_fetch_entry_s;

endpackage

// File: rtl/amber48_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue (master) and imem (slave).
interface amber48_fetch_queue_if;
  import amber48_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_err;

  modport master (output imem_req, imem_addr,
                  input  imem_gnt, imem_rvalid, imem_rdata, imem_err);
  modport slave  (input  imem_req, imem_addr,
                  output imem_gnt, imem_rvalid, imem_rdata, imem_err);

endinterface

// File: rtl/amber48_sync_fifo.sv
// Synchronous FIFO with flush; the head is read straight from storage and held once empty.
module amber48_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign doPop  = en_i && pop_i && !flush_i && (count_q != '0);
  assign doPush = en_i && push_i && !flush_i && ((count_q != CW'(DEPTH)) || doPop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (doPush) wptr_d = nextPtr(wptr_q);
      if (doPop)  rptr_d = nextPtr(rptr_q);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      if (doPush) mem_q[wptr_q] <= data_i;
      // Remember the current head so the output holds it after the queue drains.
      if (count_q != '0) last_q <= mem_q[rptr_q];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/amber48_fetch_queue.sv
// Decoupled fetch front end: issues imem requests under a credit limit and queues responses.
module amber48_fetch_queue
  import amber48_pkg::*;
#(
  parameter int              INSTR_BYTES = FETCH_INSTR_BYTES,
  parameter int              DEPTH       = FETCH_DEPTH,
  parameter int              MAX_OUTST   = FETCH_MAX_OUTST,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_en_i,
  amber48_fetch_queue_if.master  imem,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   out_valid_o,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [XLEN-1:0]        out_instr_o,
  output logic                   out_fault_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int EW = $bits(amber48_fetch_entry_s);

  logic [XLEN-1:0]             pc_q, pc_d;
  logic [OW-1:0]               outst_q, outst_d, discard_q, discard_d;
  logic                        halt_q, halt_d;
  logic                        req, fire, resp, dropResp, pushQ, popQ;
  logic [$clog2(DEPTH):0]      occ;
  logic [XLEN-1:0]             pendPc;
  logic [$clog2(MAX_OUTST):0]  pendCount;
  amber48_fetch_entry_s        entryIn, entryOut;

  // Credit check: every in-flight request already owns a queue slot.
  assign req = clk_en_i && !rst_i && !redirect_i && !halt_q &&
               (outst_q < OW'(MAX_OUTST)) &&
               ((int'(occ) + int'(outst_q)) < DEPTH);

  assign fire     = req && imem.imem_gnt;
  assign resp     = clk_en_i && imem.imem_rvalid;
  assign dropResp = resp && (redirect_i || (discard_q != '0));
  assign pushQ    = resp && !dropResp;
  assign popQ     = clk_en_i && !redirect_i && out_valid_o && out_ready_i;

  always_comb begin
    pc_d      = pc_q;
    halt_d    = halt_q;
    discard_d = discard_q;
    outst_d   = outst_q + OW'(fire) - OW'(resp);
    if (fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
    if (redirect_i) begin
      pc_d      = redirect_pc_i;
      halt_d    = 1'b0;
      // Everything still in flight after this cycle is stale, including earlier discards.
      discard_d = outst_q - OW'(resp);
    end else begin
      if (resp && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (pushQ && imem.imem_err)    halt_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      halt_q    <= 1'b0;
    end else if (clk_en_i) begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      halt_q    <= halt_d;
    end
  end

  amber48_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (clk_en_i),
    .push_i  (fire),
    .pop_i   (resp),
    .flush_i (1'b0),
    .data_i  (pc_q),
    .data_o  (pendPc),
    .count_o (pendCount)
  );

  assign entryIn.pc    = pendPc;
  assign entryIn.instr = imem.imem_rdata;
  assign entryIn.fault = imem.imem_err;

  amber48_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (clk_en_i),
    .push_i  (pushQ),
    .pop_i   (popQ),
    .flush_i (redirect_i),
    .data_i  (entryIn),
    .data_o  (entryOut),
    .count_o (occ)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign out_valid_o    = (occ != '0);
  assign out_pc_o       = entryOut.pc;
  assign out_instr_o    = entryOut.instr;
  assign out_fault_o    = entryOut.fault;
  assign occupancy_o    = occ;

  assert property (@(posedge clk_i) disable iff (rst_i) discard_q <= outst_q);
  assert property (@(posedge clk_i) disable iff (rst_i) (int'(occ) + int'(outst_q)) <= DEPTH);
  assert property (@(posedge clk_i) disable iff (rst_i) int'(pendCount) == int'(outst_q));

endmodule

// File: tb/tb_amber48_fetch_queue.sv
// Directed bench for amber48_fetch_queue with a zero-wait imem model and logged fetch stream.
module tb_amber48_fetch_queue;
  import amber48_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            clkEn;
  logic            redirect;
  logic [XLEN-1:0] redirectPc;
  logic            outValid;
  logic [XLEN-1:0] outPc;
  logic [XLEN-1:0] outInstr;
  logic            outFault;
  logic            outReady;
  logic [2:0]      occupancy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [XLEN-1:0] respQ[$];
  logic [XLEN-1:0] reqLog[$];
  logic [XLEN-1:0] outPcLog[$];
  logic [XLEN-1:0] outInstrLog[$];
  logic            faultLog[$];
  bit              memAuto;
  logic [XLEN-1:0] errAddr;

  amber48_fetch_queue_if imemIf();

  amber48_fetch_queue #(
    .INSTR_BYTES (6),
    .DEPTH       (4),
    .MAX_OUTST   (2),
    .RESET_PC    ('0)
  ) dut (
    .clk_i         (clock),
    .rst_i         (reset),
    .clk_en_i      (clkEn),
    .imem          (imemIf),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .out_valid_o   (outValid),
    .out_pc_o      (outPc),
    .out_instr_o   (outInstr),
    .out_fault_o   (outFault),
    .out_ready_i   (outReady),
    .occupancy_o   (occupancy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [XLEN-1:0] instrOf(input logic [XLEN-1:0] a);
    return a ^ 48'hA5A5_5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: present a queued memory response, log grants and consumed entries.
  task automatic applyStimulus();
    logic [XLEN-1:0] a;
    logic            grantNow;
    logic [XLEN-1:0] grantAddr;
    if (memAuto && clkEn && respQ.size() > 0) begin
      a = respQ.pop_front();
      imemIf.imem_rvalid = 1'b1;
      imemIf.imem_rdata  = instrOf(a);
      imemIf.imem_err    = (a == errAddr);
    end else begin
      imemIf.imem_rvalid = 1'b0;
      imemIf.imem_rdata  = '0;
      imemIf.imem_err    = 1'b0;
    end
    #1;
    grantNow  = imemIf.imem_req && imemIf.imem_gnt;
    grantAddr = imemIf.imem_addr;
    if (clkEn && !redirect && !reset && outValid && outReady) begin
      outPcLog.push_back(outPc);
      outInstrLog.push_back(outInstr);
      faultLog.push_back(outFault);
    end
    if (grantNow) reqLog.push_back(grantAddr);
    @(posedge clock);
    if (grantNow) respQ.push_back(grantAddr);
    @(negedge clock);
  endtask

  task automatic resetDut();
    reset              = 1'b1;
    clkEn              = 1'b1;
    redirect           = 1'b0;
    redirectPc         = '0;
    outReady           = 1'b1;
    memAuto            = 1'b1;
    errAddr            = '1;
    imemIf.imem_gnt    = 1'b1;
    imemIf.imem_rvalid = 1'b0;
    imemIf.imem_rdata  = '0;
    imemIf.imem_err    = 1'b0;
    respQ.delete();
    reqLog.delete();
    outPcLog.delete();
    outInstrLog.delete();
    faultLog.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic int countBelow(input logic [XLEN-1:0] limit);
    int n = 0;
    foreach (outPcLog[i]) if (outPcLog[i] < limit) n++;
    return n;
  endfunction

  initial begin
    reset              = 1'b1;
    clkEn              = 1'b1;
    redirect           = 1'b0;
    redirectPc         = '0;
    outReady           = 1'b1;
    memAuto            = 1'b1;
    errAddr            = '1;
    imemIf.imem_gnt    = 1'b1;
    imemIf.imem_rvalid = 1'b0;
    imemIf.imem_rdata  = '0;
    imemIf.imem_err    = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Reset state
    checkOutput("reset req",       imemIf.imem_req,  0);
    checkOutput("reset addr",      imemIf.imem_addr, 0);
    checkOutput("reset out_valid", outValid,  0);
    checkOutput("reset out_pc",    outPc,     0);
    checkOutput("reset out_instr", outInstr,  0);
    checkOutput("reset out_fault", outFault,  0);
    checkOutput("reset occupancy", occupancy, 0);
    reset = 1'b0;

    // Test 1: streaming fetch, one entry per cycle
    repeat (8) applyStimulus();
    checkOutput("t1 req count", reqLog.size(), 8);
    checkOutput("t1 req[0]",    reqLog[0], 0);
    checkOutput("t1 req[1]",    reqLog[1], 6);
    checkOutput("t1 req[2]",    reqLog[2], 12);
    checkOutput("t1 pop count", outPcLog.size(), 6);
    checkOutput("t1 pc[0]",     outPcLog[0], 0);
    checkOutput("t1 pc[1]",     outPcLog[1], 6);
    checkOutput("t1 pc[2]",     outPcLog[2], 12);
    checkOutput("t1 instr[1]",  outInstrLog[1], instrOf(48'd6));
    checkOutput("t1 occupancy", occupancy, 1);

    // Test 2: mid-operation reset, then back-pressure fills the queue
    resetDut();
    checkOutput("t2 rst occupancy", occupancy, 0);
    checkOutput("t2 rst out_valid", outValid, 0);
    checkOutput("t2 rst out_pc",    outPc, 0);
    checkOutput("t2 rst addr",      imemIf.imem_addr, 0);
    outReady = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("t2 req count", reqLog.size(), 4);
    checkOutput("t2 occupancy", occupancy, 4);
    checkOutput("t2 req low",   imemIf.imem_req, 0);
    checkOutput("t2 out_valid", outValid, 1);
    checkOutput("t2 head pc",   outPc, 0);
    outReady = 1'b1;
    repeat (8) applyStimulus();
    checkOutput("t2 drain pc[0]", outPcLog[0], 0);
    checkOutput("t2 drain pc[1]", outPcLog[1], 6);
    checkOutput("t2 drain pc[2]", outPcLog[2], 12);
    checkOutput("t2 drain pc[3]", outPcLog[3], 18);
    checkOutput("t2 resume req",  reqLog[4], 24);
    checkOutput("t2 resume pc",   outPcLog[4], 24);

    // Test 3: redirect with two requests in flight
    resetDut();
    memAuto = 1'b0;
    repeat (2) applyStimulus();
    redirect   = 1'b1;
    redirectPc = 48'h100;
    applyStimulus();
    redirect = 1'b0;
    memAuto  = 1'b1;
    checkOutput("t3 valid after redirect", outValid, 0);
    repeat (8) applyStimulus();
    checkOutput("t3 req[2]", reqLog[2], 48'h100);
    checkOutput("t3 pc[0]",  outPcLog[0], 48'h100);
    checkOutput("t3 pc[1]",  outPcLog[1], 48'h106);
    checkOutput("t3 stale",  countBelow(48'h100), 0);

    // Test 4: redirect coinciding with a response while two are outstanding
    resetDut();
    memAuto = 1'b0;
    repeat (2) applyStimulus();
    memAuto    = 1'b1;
    redirect   = 1'b1;
    redirectPc = 48'h200;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("t4 discard", dut.discard_q, 1);
    checkOutput("t4 outst",   dut.outst_q, 1);
    repeat (6) applyStimulus();
    checkOutput("t4 pc[0]",  outPcLog[0], 48'h200);
    checkOutput("t4 pc[1]",  outPcLog[1], 48'h206);
    checkOutput("t4 stale",  countBelow(48'h200), 0);

    // Test 5: bus fault halts fetch, redirect restarts it
    resetDut();
    errAddr = 48'h18;
    repeat (10) applyStimulus();
    checkOutput("t5 req count",   reqLog.size(), 6);
    checkOutput("t5 pop count",   outPcLog.size(), 6);
    checkOutput("t5 fault pc",    outPcLog[4], 48'h18);
    checkOutput("t5 fault flag",  faultLog[4], 1);
    checkOutput("t5 clean flag",  faultLog[3], 0);
    checkOutput("t5 req halted",  imemIf.imem_req, 0);
    redirect   = 1'b1;
    redirectPc = 48'h300;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("t5 N+1 valid", outValid, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("t5 N+3 valid", outValid, 1);
    checkOutput("t5 N+3 pc",    outPc, 48'h300);
    checkOutput("t5 N+3 fault", outFault, 0);
    checkOutput("t5 restart req", reqLog[6], 48'h300);

    // Test 6: PC wrap and clock-enable freeze
    resetDut();
    redirect   = 1'b1;
    redirectPc = 48'hFFFF_FFFF_FFFA;
    applyStimulus();
    redirect = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("t6 req[0]", reqLog[0], 48'hFFFF_FFFF_FFFA);
    checkOutput("t6 wrap",   reqLog[1], 0);
    checkOutput("t6 addr",   imemIf.imem_addr, 12);
    clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t6 frozen req",  imemIf.imem_req, 0);
      checkOutput("t6 frozen addr", imemIf.imem_addr, 12);
      checkOutput("t6 frozen occ",  occupancy, 1);
      checkOutput("t6 frozen pc",   outPc, 0);
    end
    clkEn = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("t6 pc[0]", outPcLog[0], 48'hFFFF_FFFF_FFFA);
    checkOutput("t6 pc[1]", outPcLog[1], 0);
    checkOutput("t6 pc[2]", outPcLog[2], 6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
